// File: rtl/uart_autobaud.sv
// Auto-baud detector: times four falling edges of a 0x55 calibration character and derives the 16x baud divisor.
// Optional define UART_AUTOBAUD_GLITCH_FILTER_EN adds a 3-sample majority filter ahead of edge detection.
module uart_autobaud #(
    parameter int DVSR_WIDTH = 11,
    parameter int CNT_WIDTH  = 20,
    parameter int DVSR_RESET = 650
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  rx,
    output logic [DVSR_WIDTH-1:0] dvsr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_START, MEASURE, COMPUTE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            edges_q, edges_d;
    logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic                  rx_f;
    logic                  fall;
    logic [CNT_WIDTH:0]    sum;
    logic [CNT_WIDTH:0]    q;
    logic [CNT_WIDTH:0]    qm1;
    logic                  bad_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_f;
        end
    end

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    logic rx_h1_q, rx_h2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_h1_q <= 1'b1;
            rx_h2_q <= 1'b1;
        end else begin
            rx_h1_q <= rx_s_q;
            rx_h2_q <= rx_h1_q;
        end
    end

    // Majority delays every real edge by one cycle, so edge-to-edge intervals are preserved.
    assign rx_f = (rx_s_q & rx_h1_q) | (rx_s_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
`else
    assign rx_f = rx_s_q;
`endif

    assign fall = rx_prev_q & ~rx_f;

    // Rounded divide by 128: 8 bit periods / (16 samples * 8 bits) = clocks per oversample tick.
    assign sum        = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(64);
    assign q          = sum >> 7;
    assign qm1        = q - (CNT_WIDTH + 1)'(1);
    assign bad_result = (q < (CNT_WIDTH + 1)'(2)) || ((qm1 >> DVSR_WIDTH) != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edges_q <= '0;
            dvsr_q  <= DVSR_WIDTH'(DVSR_RESET);
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edges_q <= edges_d;
            dvsr_q  <= dvsr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edges_d = edges_q;
        dvsr_d  = dvsr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_IDLE;
                    cnt_d   = '0;
                end
            end
            WAIT_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_WIDTH'(15)) begin
                    state_d = WAIT_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            WAIT_START: begin
                if (fall) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    edges_d = '0;
                end
            end
            MEASURE: begin
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (fall) begin
                        if (edges_q == 2'd3) begin
                            state_d = COMPUTE;
                        end else begin
                            edges_d = edges_q + 2'd1;
                        end
                    end
                end
            end
            COMPUTE: begin
                state_d = IDLE;
                if (bad_result) begin
                    err_d = 1'b1;
                end else begin
                    dvsr_d = qm1[DVSR_WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            dvsr_d  = dvsr_q;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    assign dvsr = dvsr_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: directed and randomized 0x55 calibration frames against an arithmetic model.
// A reduced counter width keeps saturation and frame runs short.
module tb_uart_autobaud;

    localparam int CW = 14;
    localparam int DW = 11;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic          rx;
    logic [DW-1:0] dvsr;
    logic          busy;
    logic          done;
    logic          err;

    int  testsRun;
    int  testsFailed;
    int  doneCnt;
    int  errCnt;
    bit  bothSeen;
    int  curDvsr;
    bit  filterEn;

    uart_autobaud #(
        .DVSR_WIDTH(DW),
        .CNT_WIDTH (CW),
        .DVSR_RESET(650)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .rx   (rx),
        .dvsr (dvsr),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (done) doneCnt++;
        if (err) errCnt++;
        if (done && err) bothSeen = 1'b1;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: measured interval in clocks -> divisor, or failure.
    function automatic void modelResult(input int countVal, output bit ok, output int value);
        int qv;
        value = 0;
        ok    = 1'b1;
        if (countVal > (2 ** CW) - 1) begin
            ok = 1'b0;
        end else begin
            qv = (countVal + 64) / 128;
            if (qv < 2 || qv - 1 > (2 ** DW) - 1) ok = 1'b0;
            else value = qv - 1;
        end
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Arms a measurement, optionally injects a 1-cycle low glitch glitchGap cycles before the frame,
    // then sends 0x55 with bit period bp; abortBit >= 0 raises abort for one cycle at that bit.
    task automatic applyStimulus(input int bp, input int glitchGap, input int abortBit);
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        pulseStart();
        idleCycles(24);
        if (glitchGap > 0) begin
            rx = 1'b0;
            idleCycles(1);
            rx = 1'b1;
            idleCycles(glitchGap - 1);
        end
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            if (i == abortBit) begin
                abort = 1'b1;
                idleCycles(1);
                abort = 1'b0;
                idleCycles(bp - 1);
            end else begin
                idleCycles(bp);
            end
        end
        rx = 1'b1;
        idleCycles(8);
    endtask

    task automatic runAndCheck(input string tag, input int bp, input int glitchGap, input int measured);
        int  d0;
        int  e0;
        bit  ok;
        int  value;
        d0 = doneCnt;
        e0 = errCnt;
        modelResult(measured, ok, value);
        applyStimulus(bp, glitchGap, -1);
        checkOutput({tag, "_done"}, doneCnt - d0, ok ? 1 : 0);
        checkOutput({tag, "_err"}, errCnt - e0, ok ? 0 : 1);
        if (ok) curDvsr = value;
        checkOutput({tag, "_dvsr"}, int'(dvsr), curDvsr);
        checkOutput({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int d0;
        int e0;
        int bp;
        int waited;
        testsRun    = 0;
        testsFailed = 0;
        doneCnt     = 0;
        errCnt      = 0;
        bothSeen    = 1'b0;
        curDvsr     = 650;
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
        filterEn = 1'b1;
`else
        filterEn = 1'b0;
`endif
        start = 1'b0;
        abort = 1'b0;
        rx    = 1'b1;
        reset = 1'b0;
        idleCycles(3);
        checkOutput("reset_dvsr", int'(dvsr), 650);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_err", int'(err), 0);
        reset = 1'b1;
        idleCycles(4);
        checkOutput("idle_no_start_busy", int'(busy), 0);

        runAndCheck("baud115200", 868, 0, 8 * 868);
        runAndCheck("two_clk_bit", 2, 0, 16);

        d0 = doneCnt;
        e0 = errCnt;
        applyStimulus(100, 0, 3);
        checkOutput("abort_done", doneCnt - d0, 0);
        checkOutput("abort_err", errCnt - e0, 0);
        checkOutput("abort_dvsr", int'(dvsr), curDvsr);
        checkOutput("abort_busy", int'(busy), 0);

        start = 1'b1;
        abort = 1'b1;
        idleCycles(1);
        start = 1'b0;
        abort = 1'b0;
        idleCycles(1);
        checkOutput("abort_beats_start", int'(busy), 0);

        pulseStart();
        idleCycles(2);
        checkOutput("busy_after_start", int'(busy), 1);
        abort = 1'b1;
        idleCycles(1);
        abort = 1'b0;
        idleCycles(1);

        for (int k = 0; k < 6; k++) begin
            bp = int'($urandom_range(2, 250));
            runAndCheck($sformatf("rand%0d_bp%0d", k, bp), bp, 0, 8 * bp);
        end

        d0 = doneCnt;
        e0 = errCnt;
        pulseStart();
        idleCycles(24);
        rx     = 1'b0;
        waited = 0;
        while (errCnt == e0 && waited < 20000) begin
            idleCycles(1);
            waited++;
        end
        checkOutput("timeout_err", errCnt - e0, 1);
        checkOutput("timeout_done", doneCnt - d0, 0);
        checkOutput("timeout_dvsr", int'(dvsr), curDvsr);
        idleCycles(2);
        checkOutput("timeout_busy", int'(busy), 0);
        rx = 1'b1;
        idleCycles(20);

        runAndCheck("glitch", 868, 100, filterEn ? 8 * 868 : 100 + 6 * 868);

        d0 = doneCnt;
        e0 = errCnt;
        pulseStart();
        idleCycles(24);
        rx = 1'b0;
        idleCycles(50);
        rx = 1'b1;
        idleCycles(50);
        reset = 1'b0;
        idleCycles(3);
        reset = 1'b1;
        curDvsr = 650;
        idleCycles(2);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_dvsr", int'(dvsr), 650);
        for (int i = 0; i < 8; i++) begin
            rx = ~rx;
            idleCycles(50);
        end
        rx = 1'b1;
        idleCycles(8);
        checkOutput("midreset_done", doneCnt - d0, 0);
        checkOutput("midreset_err", errCnt - e0, 0);
        checkOutput("midreset_stay_idle", int'(busy), 0);

        checkOutput("done_err_exclusive", int'(bothSeen), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_autobaud.md
UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 SHALL provide parameter DVSR_WIDTH, default 11, width of the divisor result (matches the baud generator dvsr input).
REQ-002 SHALL provide parameter CNT_WIDTH, default 20, width of the measurement counter.
REQ-003 SHALL provide parameter DVSR_RESET, default 650, dvsr value after reset (9600 baud at 100 MHz, 16x oversampling).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to arm a measurement.
REQ-007 SHALL have port abort  input  1  cancel any measurement in progress.
REQ-008 SHALL have port rx  input  1  asynchronous UART line, idle high.
REQ-009 SHALL have port dvsr  output  DVSR_WIDTH  last valid divisor, for direct connection to the baud generator.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a new dvsr is written.
REQ-012 SHALL have port err  output  1  one-cycle pulse on failed measurement; dvsr unchanged.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all detection uses the synchronized signal rx_s.
REQ-014 SHALL detect a falling edge when rx_s is 0 and its previous registered value is 1.
REQ-015 SHALL implement states IDLE, WAIT_IDLE, WAIT_START, MEASURE, COMPUTE.
REQ-016 IDLE: on start go to WAIT_IDLE; start SHALL be ignored in every other state.
REQ-017 WAIT_IDLE: go to WAIT_START after 16 consecutive cycles with rx_s high, so a measurement never begins mid-frame.
REQ-018 WAIT_START: on a falling edge, clear the counter and the edge count, then go to MEASURE.
REQ-019 MEASURE: increment the counter every cycle and count falling edges; on the 4th edge after the start edge go to COMPUTE, leaving the counter at 8 bit periods for a 0x55 calibration character.
REQ-020 COMPUTE, one cycle: q = (count + 64) >> 7; result = q - 1; return to IDLE.
REQ-021 A valid result SHALL be registered into dvsr with done high in the cycle after COMPUTE.
REQ-022 If q < 2, or q - 1 > 2^DVSR_WIDTH - 1, err SHALL pulse instead of done and dvsr SHALL hold its value.
REQ-023 If the counter reaches all-ones in MEASURE, err SHALL pulse the next cycle and the FSM SHALL go to IDLE (timeout).
REQ-024 abort SHALL force IDLE on the next edge from any state, with no done and no err; abort SHALL win over start in the same cycle.
REQ-025 done and err SHALL never be high in the same cycle.

Reset
REQ-026 On reset low: state IDLE, dvsr = DVSR_RESET, busy = 0, done = 0, err = 0, counter and edge count 0, synchronizer flops 1.
REQ-027 Reset asserted mid-measurement SHALL discard the measurement; after release the block SHALL stay IDLE until start.

Configuration
REQ-028 With UART_AUTOBAUD_GLITCH_FILTER_EN defined, rx_s SHALL pass through a 3-sample majority filter before edge detection, adding one cycle to every edge so the measured interval is unchanged; pulses of 1 cycle SHALL be rejected.
REQ-029 Without UART_AUTOBAUD_GLITCH_FILTER_EN, edges are taken directly from rx_s and single-cycle glitches count as edges.

Verification
REQ-030 Reset, no start -> dvsr = 650, busy = 0, done = 0, err = 0.
REQ-031 start, then 0x55 at 9600 baud (10417 clk per bit, 100 MHz) -> count 83336, done pulse, dvsr = 650.
REQ-032 start, then 0x55 at 115200 baud (868 clk per bit) -> count 6944, done pulse, dvsr = 53.
REQ-033 start, then one falling edge and rx held low -> counter saturates at 2^20 - 1, err pulse, dvsr unchanged, busy = 0.
REQ-034 start, then 0x55 at 2 clk per bit -> q = 0, err pulse, dvsr unchanged; abort asserted mid-MEASURE in a repeat run -> IDLE, no done, no err.
REQ-035 With the macro defined, a 1-cycle low glitch injected before 0x55 at 115200 baud -> dvsr = 53; without the macro, the same stimulus -> dvsr differs from 53.
